// File: rtl/painterengine_gpu_dma_writer_mc_if.sv
// AXI4 write-channel bundle (AW, W, B) between the GPU write DMA and the interconnect.
// Master drives addresses, beats and BREADY; slave drives readies and responses.
interface painterengine_gpu_dma_writer_mc_if #(
    parameter int PARAM_DATA_WIDTH = 32
);
    logic                          o_wire_M_AXI_AWID;
    logic [31:0]                   o_wire_M_AXI_AWADDR;
    logic [7:0]                    o_wire_M_AXI_AWLEN;
    logic [2:0]                    o_wire_M_AXI_AWSIZE;
    logic [1:0]                    o_wire_M_AXI_AWBURST;
    logic                          o_wire_M_AXI_AWLOCK;
    logic [3:0]                    o_wire_M_AXI_AWCACHE;
    logic [2:0]                    o_wire_M_AXI_AWPROT;
    logic [3:0]                    o_wire_M_AXI_AWQOS;
    logic                          o_wire_M_AXI_AWVALID;
    logic                          i_wire_M_AXI_AWREADY;
    logic [PARAM_DATA_WIDTH-1:0]   o_wire_M_AXI_WDATA;
    logic [PARAM_DATA_WIDTH/8-1:0] o_wire_M_AXI_WSTRB;
    logic                          o_wire_M_AXI_WLAST;
    logic                          o_wire_M_AXI_WVALID;
    logic                          i_wire_M_AXI_WREADY;
    logic                          i_wire_M_AXI_BID;
    logic [1:0]                    i_wire_M_AXI_BRESP;
    logic                          i_wire_M_AXI_BVALID;
    logic                          o_wire_M_AXI_BREADY;

    modport master (
        output o_wire_M_AXI_AWID, o_wire_M_AXI_AWADDR, o_wire_M_AXI_AWLEN, o_wire_M_AXI_AWSIZE,
               o_wire_M_AXI_AWBURST, o_wire_M_AXI_AWLOCK, o_wire_M_AXI_AWCACHE, o_wire_M_AXI_AWPROT,
               o_wire_M_AXI_AWQOS, o_wire_M_AXI_AWVALID, o_wire_M_AXI_WDATA, o_wire_M_AXI_WSTRB,
               o_wire_M_AXI_WLAST, o_wire_M_AXI_WVALID, o_wire_M_AXI_BREADY,
        input  i_wire_M_AXI_AWREADY, i_wire_M_AXI_WREADY, i_wire_M_AXI_BID, i_wire_M_AXI_BRESP,
               i_wire_M_AXI_BVALID
    );

    modport slave (
        input  o_wire_M_AXI_AWID, o_wire_M_AXI_AWADDR, o_wire_M_AXI_AWLEN, o_wire_M_AXI_AWSIZE,
               o_wire_M_AXI_AWBURST, o_wire_M_AXI_AWLOCK, o_wire_M_AXI_AWCACHE, o_wire_M_AXI_AWPROT,
               o_wire_M_AXI_AWQOS, o_wire_M_AXI_AWVALID, o_wire_M_AXI_WDATA, o_wire_M_AXI_WSTRB,
               o_wire_M_AXI_WLAST, o_wire_M_AXI_WVALID, o_wire_M_AXI_BREADY,
        output i_wire_M_AXI_AWREADY, i_wire_M_AXI_WREADY, i_wire_M_AXI_BID, i_wire_M_AXI_BRESP,
               i_wire_M_AXI_BVALID
    );
endinterface

// File: rtl/painterengine_gpu_dma_writer_mc.sv
// Multi-channel AXI4 INCR burst write DMA; bursts split at PARAM_MAX_BURST beats and 4 KB.
// Latency: 3 cycles start->AWVALID; W beats stall on source valid or WREADY, one burst outstanding.
module painterengine_gpu_dma_writer_mc #(
    parameter int PARAM_CHANNELS   = 4,
    parameter int PARAM_DATA_WIDTH = 32,
    parameter int PARAM_MAX_BURST  = 256,
    parameter int PARAM_TIMEOUT    = 256
) (
    input  logic                                   i_wire_clock,
    input  logic                                   i_wire_resetn,
    input  logic                                   i_wire_start,
    input  logic [PARAM_CHANNELS-1:0]              i_wire_router,
    input  logic [32*PARAM_CHANNELS-1:0]           i_wire_address,
    input  logic [32*PARAM_CHANNELS-1:0]           i_wire_length,
    input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
    input  logic [PARAM_CHANNELS-1:0]              i_wire_data_valid,
    output logic [PARAM_CHANNELS-1:0]              o_wire_data_next,
    output logic                                   o_wire_busy,
    output logic                                   o_wire_done,
    output logic                                   o_wire_error,
    output logic [2:0]                             o_wire_error_type,
    painterengine_gpu_dma_writer_mc_if.master      m_axi
);
    localparam int BYTES = PARAM_DATA_WIDTH / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int CW    = (PARAM_CHANNELS > 1) ? $clog2(PARAM_CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CALC, S_AW, S_W, S_B, S_DONE, S_ERROR
    } state_t;

    state_t                    r_state, w_next;
    logic [31:0]               r_addr, r_remain;
    logic [CW-1:0]             r_ch, w_sel_idx;
    logic [PARAM_CHANNELS-1:0] r_router;
    logic [8:0]                r_burst, r_beat;
    logic [15:0]               r_tmo;
    logic [2:0]                r_err, w_err_code;

    logic                        w_ch_valid, w_aw_fire, w_w_fire, w_b_fire, w_hs, w_last, w_onehot;
    logic [PARAM_DATA_WIDTH-1:0] w_ch_data;
    logic [12:0]                 w_to4k;
    logic [8:0]                  w_tomax, w_awlen9;
    logic [31:0]                 w_burst_c;
    logic                        w_unused;

    // Lowest set router bit names the channel; a bad router is rejected in CHECK anyway.
    always_comb begin
        w_sel_idx = '0;
        for (int i = PARAM_CHANNELS - 1; i >= 0; i--)
            if (i_wire_router[i]) w_sel_idx = CW'(i);
    end

    assign w_ch_valid = i_wire_data_valid[r_ch];
    assign w_ch_data  = i_wire_data[r_ch*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
    assign w_aw_fire  = (r_state == S_AW) && m_axi.i_wire_M_AXI_AWREADY;
    assign w_w_fire   = (r_state == S_W) && w_ch_valid && m_axi.i_wire_M_AXI_WREADY;
    assign w_b_fire   = (r_state == S_B) && m_axi.i_wire_M_AXI_BVALID;
    assign w_hs       = w_aw_fire || w_w_fire || w_b_fire;
    assign w_last     = (r_beat == r_burst - 9'd1);
    assign w_onehot   = (r_router != '0) && ((r_router & (r_router - 1'b1)) == '0);
    assign w_awlen9   = r_burst - 9'd1;
    assign w_unused   = ^{m_axi.i_wire_M_AXI_BID, m_axi.i_wire_M_AXI_BRESP[0]};

    assign w_to4k  = (13'd4096 - {1'b0, r_addr[11:0]}) >> BL;
    assign w_tomax = 9'(PARAM_MAX_BURST) - 9'((r_addr >> BL) & 32'(PARAM_MAX_BURST - 1));

    always_comb begin
        w_burst_c = r_remain;
        if (32'(w_to4k) < w_burst_c)  w_burst_c = 32'(w_to4k);
        if (32'(w_tomax) < w_burst_c) w_burst_c = 32'(w_tomax);
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_err_code = 3'd0;
        case (r_state)
            S_IDLE:  if (i_wire_start) w_next = S_CHECK;
            S_CHECK: begin
                if (!w_onehot)                     begin w_next = S_ERROR; w_err_code = 3'd1; end
                else if (r_addr[BL-1:0] != '0)     begin w_next = S_ERROR; w_err_code = 3'd2; end
                else if (r_remain == 32'd0)        begin w_next = S_ERROR; w_err_code = 3'd3; end
                else                               w_next = S_CALC;
            end
            S_CALC:  w_next = S_AW;
            S_AW:    if (w_aw_fire) w_next = S_W;
            S_W:     if (w_w_fire && w_last) w_next = S_B;
            S_B: begin
                if (w_b_fire) begin
                    if (m_axi.i_wire_M_AXI_BRESP[1]) begin w_next = S_ERROR; w_err_code = 3'd4; end
                    else if (r_remain == 32'd0)      w_next = S_DONE;
                    else                             w_next = S_CALC;
                end
            end
            S_DONE, S_ERROR: if (!i_wire_start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if ((r_state inside {S_AW, S_W, S_B}) && !w_hs && (r_tmo == 16'(PARAM_TIMEOUT - 1))) begin
            w_next     = S_ERROR;
            w_err_code = 3'd5;
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_ch     <= '0;
            r_router <= '0;
            r_burst  <= '0;
            r_beat   <= '0;
            r_tmo    <= '0;
            r_err    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_wire_start) begin
                    r_addr   <= i_wire_address[w_sel_idx*32 +: 32];
                    r_remain <= i_wire_length[w_sel_idx*32 +: 32];
                    r_ch     <= w_sel_idx;
                    r_router <= i_wire_router;
                end
                S_CALC: r_burst <= w_burst_c[8:0];
                S_AW:   if (w_aw_fire) r_beat <= '0;
                S_W:    if (w_w_fire) begin
                    r_beat <= r_beat + 9'd1;
                    if (w_last) begin
                        r_addr   <= r_addr + (32'(r_burst) << BL);
                        r_remain <= r_remain - 32'(r_burst);
                    end
                end
                default: ;
            endcase
            // Stall counter restarts on every handshake and every state change.
            if ((r_state != w_next) || w_hs || !(r_state inside {S_AW, S_W, S_B})) r_tmo <= '0;
            else                                                                 r_tmo <= r_tmo + 16'd1;
            if ((w_next == S_ERROR) && (r_state != S_ERROR)) r_err <= w_err_code;
            else if ((r_state == S_ERROR) && !i_wire_start)  r_err <= '0;
        end
    end

    // AW attributes are only driven while AWVALID is up so every output is 0 when idle.
    assign m_axi.o_wire_M_AXI_AWVALID = (r_state == S_AW);
    assign m_axi.o_wire_M_AXI_AWADDR  = m_axi.o_wire_M_AXI_AWVALID ? r_addr : '0;
    assign m_axi.o_wire_M_AXI_AWLEN   = m_axi.o_wire_M_AXI_AWVALID ? w_awlen9[7:0] : '0;
    assign m_axi.o_wire_M_AXI_AWSIZE  = m_axi.o_wire_M_AXI_AWVALID ? 3'(BL) : '0;
    assign m_axi.o_wire_M_AXI_AWBURST = m_axi.o_wire_M_AXI_AWVALID ? 2'b01 : '0;
    assign m_axi.o_wire_M_AXI_AWCACHE = m_axi.o_wire_M_AXI_AWVALID ? 4'b0010 : '0;
    assign m_axi.o_wire_M_AXI_AWID    = 1'b0;
    assign m_axi.o_wire_M_AXI_AWLOCK  = 1'b0;
    assign m_axi.o_wire_M_AXI_AWPROT  = 3'd0;
    assign m_axi.o_wire_M_AXI_AWQOS   = 4'd0;
    assign m_axi.o_wire_M_AXI_WVALID  = (r_state == S_W) && w_ch_valid;
    assign m_axi.o_wire_M_AXI_WDATA   = (r_state == S_W) ? w_ch_data : '0;
    assign m_axi.o_wire_M_AXI_WSTRB   = (r_state == S_W) ? '1 : '0;
    assign m_axi.o_wire_M_AXI_WLAST   = (r_state == S_W) && w_last;
    assign m_axi.o_wire_M_AXI_BREADY  = (r_state == S_B);

    assign o_wire_data_next  = w_w_fire ? (PARAM_CHANNELS'(1) << r_ch) : '0;
    assign o_wire_busy       = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign o_wire_done       = (r_state == S_DONE);
    assign o_wire_error      = (r_state == S_ERROR);
    assign o_wire_error_type = r_err;
endmodule

// File: doc/painterengine_gpu_dma_writer_mc.md
Name: painterengine_gpu_dma_writer_mc

Overview:
Parametrised multi-channel AXI4 burst write DMA for the PainterEngine GPU. One of PARAM_CHANNELS streaming sources is selected per job by a one-hot router. That source's beats are written to memory as a sequence of INCR bursts. Bursts are split so none exceeds PARAM_MAX_BURST beats or crosses a 4 KB boundary. Sits between the GPU render/blit engines (stream producers) and the AXI interconnect.

Parameters:
PARAM_CHANNELS, 4, number of source channels (1..8).
PARAM_DATA_WIDTH, 32, AXI/stream beat width in bits (32, 64 or 128).
PARAM_MAX_BURST, 256, maximum beats per burst (power of 2, 1..256).
PARAM_TIMEOUT, 256, consecutive stall cycles before timeout error (2..65535).

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  async active-low reset
i_wire_start  in  1  level; job request, sampled in IDLE
i_wire_router  in  PARAM_CHANNELS  one-hot channel select
i_wire_address  in  32*PARAM_CHANNELS  per-channel byte start address
i_wire_length  in  32*PARAM_CHANNELS  per-channel length in beats
i_wire_data  in  PARAM_DATA_WIDTH*PARAM_CHANNELS  per-channel beat data
i_wire_data_valid  in  PARAM_CHANNELS  per-channel beat valid
o_wire_data_next  out  PARAM_CHANNELS  per-channel beat consumed
o_wire_busy / o_wire_done / o_wire_error  out  1 each  status
o_wire_error_type  out  3  error code
o_wire_M_AXI_AW*: AWID 1, AWADDR 32, AWLEN 8, AWSIZE 3, AWBURST 2, AWLOCK 1, AWCACHE 4, AWPROT 3, AWQOS 4, AWVALID 1 out; AWREADY 1 in
o_wire_M_AXI_W*: WDATA DW, WSTRB DW/8, WLAST 1, WVALID 1 out; WREADY 1 in
i_wire_M_AXI_BID 1, BRESP 2, BVALID 1 in; o_wire_M_AXI_BREADY 1 out

Behaviour:
- Constant AXI fields: AWID=0, AWSIZE=log2(DW/8), AWBURST=01, AWLOCK=0, AWCACHE=0010, AWPROT=0, AWQOS=0, WSTRB all ones.
- Reset values: all outputs 0, state IDLE, error_type 0.
- Byte count per beat: BYTES=DW/8.
- States and transitions:
  - IDLE: when start=1, latch address, length and channel index from router; go to CHECK.
  - CHECK: in priority order, router not one-hot -> ERROR(1); address not BYTES-aligned -> ERROR(2); length==0 -> ERROR(3); otherwise CALC.
  - CALC (one cycle): compute beats to 4 KB boundary = (4096 - addr[11:0])/BYTES, and beats to max-burst boundary = PARAM_MAX_BURST - ((addr/BYTES) mod PARAM_MAX_BURST). burstlen = min(remaining, to-4K, to-max). Then go to AW.
  - AW: AWVALID=1, with AWADDR and AWLEN=burstlen-1 held stable until AWREADY. On the handshake, drop AWVALID, clear beat counter, go to W.
  - W: WVALID = data_valid[ch]. WDATA = data[ch*DW +: DW]. WLAST is combinational: beat counter == burstlen-1. A beat transfers when WVALID && WREADY; that beat's data_next[ch]=1, and all other channels' data_next stay 0. On the last transfer, addr += burstlen*BYTES, remaining -= burstlen, go to B.
  - B: BREADY=1. On BVALID: BRESP[1]=1 -> ERROR(4); else if remaining==0 -> DONE; else CALC.
  - DONE / ERROR: sticky; done or error held high. When start=0, return to IDLE and clear error_type.
- busy=1 in every state except IDLE, DONE and ERROR.
- Timeout: counter clears on any AW, W or B handshake and on state entry. It increments in AW, W and B on cycles without a handshake. Reaching PARAM_TIMEOUT -> ERROR(5) and deassert all AXI valids/readies.
- Error codes: 0 ok, 1 routing, 2 alignment, 3 zero length, 4 bad BRESP, 5 timeout.
- Only one burst is outstanding at a time. No W beat is issued before its AW handshake.
- Length and address arithmetic is 32-bit; wrap past 0xFFFFFFFF is undefined and not checked.
- Job inputs are ignored after IDLE; changes mid-job have no effect.
- Reset mid-operation returns to IDLE immediately; AXI valids drop asynchronously.

Test Plan:
- ch0, addr 0x1000, len 4, DW32, always ready -> one burst AWADDR 0x1000 AWLEN 3; 4 beats with WLAST on beat 4; done after BVALID; data_next[3:1] never high.
- ch2, addr 0x0FF8, len 8, DW32 -> two bursts: 0x0FF8 len 2, then 0x1000 len 6 (4 KB split).
- ch1, addr 0, len 300, MAX_BURST 256 -> bursts of 256 at 0x0 and 44 at 0x400. Random WREADY/valid gaps: all 300 beats in order, none dropped or duplicated.
- router 0b0110 -> error_type 1; addr 0x2 -> 2; len 0 -> 3; BRESP=2'b10 on first burst -> 4. Each is sticky until start=0, then IDLE.
- AWREADY held 0 for PARAM_TIMEOUT cycles -> error_type 5, AWVALID drops.
- Reset asserted during beat 10 of a 16-beat burst -> all outputs 0 that cycle. A new job afterwards completes normally.
